// File: rtl/wt_cache_pkg.sv
// Shared constants and types for the write-through L1 data cache.
package wt_cache_pkg;

    localparam int unsigned DCACHE_NUM_RD_PORTS    = 4;
    localparam int unsigned DCACHE_RD_STARVE_LIMIT = 16;

    typedef logic [$clog2(DCACHE_NUM_RD_PORTS)-1:0] dcache_rd_sel_t;

endpackage

// File: rtl/wt_dcache_rd_arb_if.sv
// Request/grant bundle between the dcache requesters and the array read arbiter.
interface wt_dcache_rd_arb_if #(
    parameter int unsigned NumPorts = 4
);
    localparam int unsigned SelW = $clog2(NumPorts);

    // Handshake: each rd_req_i bit / wr_req_i is held by its requester until the
    // matching rd_ack_o bit / wr_ack_o is seen high in the same cycle; the
    // transfer happens on that clock edge. Dropping a request before the ack
    // is allowed and simply withdraws it.
    logic [NumPorts-1:0] rd_req_i;
    logic [NumPorts-1:0] rd_prio_i;
    logic [NumPorts-1:0] rd_tag_only_i;
    logic                wr_cl_vld_i;
    logic                wr_req_i;
    logic [NumPorts-1:0] rd_ack_o;
    logic [SelW-1:0]     rd_sel_o;
    logic                wr_ack_o;
    logic                rd_vld_q_o;
    logic [SelW-1:0]     rd_port_q_o;
    logic                rd_tag_only_q_o;

    modport slave (
        input  rd_req_i, rd_prio_i, rd_tag_only_i, wr_cl_vld_i, wr_req_i,
        output rd_ack_o, rd_sel_o, wr_ack_o, rd_vld_q_o, rd_port_q_o, rd_tag_only_q_o
    );

    modport master (
        output rd_req_i, rd_prio_i, rd_tag_only_i, wr_cl_vld_i, wr_req_i,
        input  rd_ack_o, rd_sel_o, wr_ack_o, rd_vld_q_o, rd_port_q_o, rd_tag_only_q_o
    );

endinterface

// File: rtl/wt_dcache_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping.
module wt_dcache_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         vld,
    output logic [W-1:0] idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            automatic int unsigned j = (32'(ptr) + i) % N;
            if (!vld && req[j]) begin
                vld = 1'b1;
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Arbiter for the dcache tag/data read port and word-write port, with
// starvation bounds for low-priority reads and word writes.
module wt_dcache_rd_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts    = DCACHE_NUM_RD_PORTS,
    parameter int unsigned StarveLimit = DCACHE_RD_STARVE_LIMIT
) (
    input logic clk_i,
    input logic rst_ni,
    wt_dcache_rd_arb_if.slave arb
);

    localparam int unsigned SelW = $clog2(NumPorts);
    localparam int unsigned CntW = $clog2(StarveLimit);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit - 1);

    logic [NumPorts-1:0] hp_req, lp_req;
    logic                hp_vld, lp_vld;
    logic [SelW-1:0]     hp_idx, lp_idx;
    logic [SelW-1:0]     rr_q, rr_d;
    logic [CntW-1:0]     lp_starve_q, wr_starve_q;
    logic                force_wr, force_lp, lp_ack;
    logic [NumPorts-1:0] ack;
    logic [SelW-1:0]     sel;
    logic                wr_ack;
    logic                vld_q, tag_only_q;
    logic [SelW-1:0]     port_q;

    assign hp_req = arb.rd_req_i & arb.rd_prio_i;
    assign lp_req = arb.rd_req_i & ~arb.rd_prio_i;

    wt_dcache_rr_pick #(.N(NumPorts)) i_hp_pick (
        .req (hp_req),
        .ptr (rr_q),
        .vld (hp_vld),
        .idx (hp_idx)
    );

    wt_dcache_rr_pick #(.N(NumPorts)) i_lp_pick (
        .req (lp_req),
        .ptr (rr_q),
        .vld (lp_vld),
        .idx (lp_idx)
    );

    // A forced word write outranks a forced read; the read counter stays
    // saturated, so the read is forced on the following cycle.
    assign force_wr = arb.wr_req_i && (wr_starve_q == CntMax);
    assign force_lp = lp_vld && (lp_starve_q == CntMax);

    always_comb begin
        ack    = '0;
        sel    = '0;
        wr_ack = 1'b0;
        if (!arb.wr_cl_vld_i) begin
            if (force_wr) begin
                wr_ack = 1'b1;
            end else if (force_lp) begin
                ack[lp_idx] = 1'b1;
                sel         = lp_idx;
            end else if (hp_vld) begin
                ack[hp_idx] = 1'b1;
                sel         = hp_idx;
            end else if (lp_vld) begin
                ack[lp_idx] = 1'b1;
                sel         = lp_idx;
            end else if (arb.wr_req_i) begin
                wr_ack = 1'b1;
            end
        end
    end

    assign lp_ack = |(ack & ~arb.rd_prio_i);
    assign rr_d   = (sel == SelW'(NumPorts - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            lp_starve_q <= '0;
            wr_starve_q <= '0;
            vld_q       <= 1'b0;
            port_q      <= '0;
            tag_only_q  <= 1'b0;
        end else begin
            vld_q <= |ack;
            if (|ack) begin
                rr_q       <= rr_d;
                port_q     <= sel;
                tag_only_q <= arb.rd_tag_only_i[sel];
            end
            if (!lp_vld || lp_ack) begin
                lp_starve_q <= '0;
            end else if (lp_starve_q != CntMax) begin
                lp_starve_q <= lp_starve_q + 1'b1;
            end
            if (!arb.wr_req_i || wr_ack) begin
                wr_starve_q <= '0;
            end else if (wr_starve_q != CntMax) begin
                wr_starve_q <= wr_starve_q + 1'b1;
            end
        end
    end

    assign arb.rd_ack_o        = ack;
    assign arb.rd_sel_o        = sel;
    assign arb.wr_ack_o        = wr_ack;
    assign arb.rd_vld_q_o      = vld_q;
    assign arb.rd_port_q_o     = port_q;
    assign arb.rd_tag_only_q_o = tag_only_q;

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Self-checking bench for wt_dcache_rd_arb: directed scenarios plus randomized
// traffic against a behavioural arbitration model.
module tb_wt_dcache_rd_arb;

    localparam int N  = 4;
    localparam int L  = 16;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    wt_dcache_rd_arb_if #(.NumPorts(N)) bus ();

    wt_dcache_rd_arb #(.NumPorts(N), .StarveLimit(L)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .arb    (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int   m_rr, m_lp, m_wr, m_port;
    bit   m_vld, m_tag;
    // current cycle stimulus and expected grant
    logic [N-1:0] prio;
    logic [N-1:0] c_req, c_tag;
    bit           c_cl, c_wr;
    logic [N-1:0] e_ack;
    int           e_sel;
    bit           e_wr;

    function automatic int pick(input logic [N-1:0] m, input int start);
        for (int off = 0; off < N; off++) begin
            if (m[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    task automatic model_comb();
        int hp_p, lp_p;
        hp_p  = pick(c_req & prio, m_rr);
        lp_p  = pick(c_req & ~prio, m_rr);
        e_ack = '0;
        e_sel = 0;
        e_wr  = 1'b0;
        if (c_cl) begin
        end else if (c_wr && m_wr == L - 1) begin
            e_wr = 1'b1;
        end else if (lp_p >= 0 && m_lp == L - 1) begin
            e_sel = lp_p;
        end else if (hp_p >= 0) begin
            e_sel = hp_p;
        end else if (lp_p >= 0) begin
            e_sel = lp_p;
        end else if (c_wr) begin
            e_wr = 1'b1;
        end
        if (!c_cl && !e_wr && (hp_p >= 0 || lp_p >= 0)) e_ack[e_sel] = 1'b1;
    endtask

    task automatic model_clock();
        bit lp_pend, lp_got;
        lp_pend = |(c_req & ~prio);
        lp_got  = |(e_ack & ~prio);
        m_vld   = (e_ack != '0);
        if (e_ack != '0) begin
            m_rr   = (e_sel + 1) % N;
            m_port = e_sel;
            m_tag  = c_tag[e_sel];
        end
        if (!lp_pend || lp_got) m_lp = 0;
        else if (m_lp < L - 1) m_lp = m_lp + 1;
        if (!c_wr || e_wr) m_wr = 0;
        else if (m_wr < L - 1) m_wr = m_wr + 1;
    endtask

    task automatic model_reset();
        m_rr = 0; m_lp = 0; m_wr = 0; m_port = 0; m_vld = 0; m_tag = 0;
        c_req = '0; c_tag = '0; c_cl = 0; c_wr = 0;
        e_ack = '0; e_sel = 0; e_wr = 0;
        bus.rd_req_i = '0; bus.rd_tag_only_i = '0;
        bus.wr_cl_vld_i = 1'b0; bus.wr_req_i = 1'b0;
    endtask

    // One cycle: close the previous cycle in the model, drive new inputs just
    // after the edge and return mid-cycle, ready for sampling.
    task automatic apply(input logic [N-1:0] req, input logic [N-1:0] tag,
                         input bit cl, input bit wr);
        @(posedge clk);
        model_clock();
        #1;
        c_req = req; c_tag = tag; c_cl = cl; c_wr = wr;
        bus.rd_req_i = req; bus.rd_tag_only_i = tag;
        bus.wr_cl_vld_i = cl; bus.wr_req_i = wr; bus.rd_prio_i = prio;
        model_comb();
        #2;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        bus.rd_prio_i = prio;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        prio = 4'b0011;
        rst_ni = 1'b0;
        model_reset();
        bus.rd_prio_i = prio;
        repeat (2) @(posedge clk);
        #2;
        total++; if (bus.rd_ack_o !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b exp 0000", bus.rd_ack_o); end
        total++; if (bus.rd_sel_o !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d exp 0", bus.rd_sel_o); end
        total++; if (bus.wr_ack_o !== 1'b0) begin bad++; $display("FAIL reset_wr_ack: got %b exp 0", bus.wr_ack_o); end
        total++; if (bus.rd_vld_q_o !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b exp 0", bus.rd_vld_q_o); end
        total++; if (bus.rd_port_q_o !== 2'd0) begin bad++; $display("FAIL reset_port: got %0d exp 0", bus.rd_port_q_o); end
        total++; if (bus.rd_tag_only_q_o !== 1'b0) begin bad++; $display("FAIL reset_tag: got %b exp 0", bus.rd_tag_only_q_o); end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_hp_rr();
        logic [N-1:0] exp_ack [4];
        exp_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        for (int c = 0; c < 5; c++) begin
            apply((c < 4) ? 4'b0011 : 4'b0000, 4'b0000, 1'b0, 1'b0);
            if (c < 4) begin
                total++; if (bus.rd_ack_o !== exp_ack[c]) begin bad++; $display("FAIL hp_rr_ack c%0d: got %b exp %b", c, bus.rd_ack_o, exp_ack[c]); end
            end
            total++; if (bus.rd_vld_q_o !== (c > 0)) begin bad++; $display("FAIL hp_rr_vld c%0d: got %b exp %b", c, bus.rd_vld_q_o, c > 0); end
            if (c > 0) begin
                total++; if (bus.rd_port_q_o !== SW'((c - 1) % 2)) begin bad++; $display("FAIL hp_rr_port c%0d: got %0d exp %0d", c, bus.rd_port_q_o, (c - 1) % 2); end
            end
        end
    endtask

    task automatic test_lp_starve();
        apply('0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            apply((c <= 16) ? 4'b1011 : 4'b0011, 4'b0000, 1'b0, 1'b0);
            total++; if (bus.rd_ack_o !== e_ack) begin bad++; $display("FAIL lp_starve_model c%0d: got %b exp %b", c, bus.rd_ack_o, e_ack); end
            if (c < 16) begin
                total++; if (bus.rd_ack_o[3] !== 1'b0 || bus.rd_ack_o[1:0] == 2'b00) begin bad++; $display("FAIL lp_starve_early c%0d: got %b exp hp grant", c, bus.rd_ack_o); end
            end else if (c == 16) begin
                total++; if (bus.rd_ack_o !== 4'b1000) begin bad++; $display("FAIL lp_starve_forced: got %b exp 1000", bus.rd_ack_o); end
            end else begin
                total++; if (bus.rd_ack_o !== 4'b0001) begin bad++; $display("FAIL lp_starve_resume: got %b exp 0001", bus.rd_ack_o); end
            end
        end
        apply('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_cl_block();
        apply('0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            apply(4'b0001, '0, 1'b1, 1'b1);
            total++; if (bus.rd_ack_o !== 4'b0000 || bus.wr_ack_o !== 1'b0) begin bad++; $display("FAIL cl_block c%0d: got rd=%b wr=%b exp 0000/0", c, bus.rd_ack_o, bus.wr_ack_o); end
        end
        apply(4'b0001, '0, 1'b0, 1'b1);
        total++; if (bus.rd_ack_o !== 4'b0001 || bus.wr_ack_o !== 1'b0) begin bad++; $display("FAIL cl_rd_after: got rd=%b wr=%b exp 0001/0", bus.rd_ack_o, bus.wr_ack_o); end
        apply(4'b0000, '0, 1'b0, 1'b1);
        total++; if (bus.rd_ack_o !== 4'b0000 || bus.wr_ack_o !== 1'b1) begin bad++; $display("FAIL cl_wr_after: got rd=%b wr=%b exp 0000/1", bus.rd_ack_o, bus.wr_ack_o); end
        apply('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_both_forced();
        apply('0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            apply(4'b1011, '0, 1'b0, 1'b1);
            total++; if (bus.wr_ack_o !== 1'b0 || bus.rd_ack_o[3] !== 1'b0) begin bad++; $display("FAIL both_pre c%0d: got rd=%b wr=%b exp hp only", c, bus.rd_ack_o, bus.wr_ack_o); end
        end
        apply(4'b1011, '0, 1'b0, 1'b1);
        total++; if (bus.wr_ack_o !== 1'b1 || bus.rd_ack_o !== 4'b0000) begin bad++; $display("FAIL both_wr_first: got rd=%b wr=%b exp 0000/1", bus.rd_ack_o, bus.wr_ack_o); end
        apply(4'b1011, '0, 1'b0, 1'b0);
        total++; if (bus.rd_ack_o !== 4'b1000 || bus.wr_ack_o !== 1'b0) begin bad++; $display("FAIL both_rd_next: got rd=%b wr=%b exp 1000/0", bus.rd_ack_o, bus.wr_ack_o); end
        apply('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply(4'b0001, 4'b0000, 1'b0, 1'b0);
        apply(4'b0001, 4'b0001, 1'b0, 1'b0);
        total++; if (bus.rd_ack_o !== 4'b0001) begin bad++; $display("FAIL rst_mid_ack: got %b exp 0001", bus.rd_ack_o); end
        #1;
        rst_ni = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        total++; if (bus.rd_vld_q_o !== 1'b0) begin bad++; $display("FAIL rst_mid_vld: got %b exp 0", bus.rd_vld_q_o); end
        total++; if (bus.rd_port_q_o !== 2'd0) begin bad++; $display("FAIL rst_mid_port: got %0d exp 0", bus.rd_port_q_o); end
        total++; if (bus.rd_tag_only_q_o !== 1'b0) begin bad++; $display("FAIL rst_mid_tag: got %b exp 0", bus.rd_tag_only_q_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        apply(4'b0011, 4'b0000, 1'b0, 1'b0);
        total++; if (bus.rd_ack_o !== 4'b0001) begin bad++; $display("FAIL rst_mid_rr: got %b exp 0001", bus.rd_ack_o); end
        apply('0, '0, 1'b0, 1'b0);
        total++; if (bus.rd_vld_q_o !== 1'b1 || bus.rd_port_q_o !== 2'd0) begin bad++; $display("FAIL rst_mid_after: got vld=%b port=%0d exp 1/0", bus.rd_vld_q_o, bus.rd_port_q_o); end
    endtask

    task automatic test_word_write();
        apply('0, '0, 1'b0, 1'b0);
        apply('0, '0, 1'b0, 1'b1);
        total++; if (bus.wr_ack_o !== 1'b1 || bus.rd_ack_o !== 4'b0000) begin bad++; $display("FAIL ww_ack: got rd=%b wr=%b exp 0000/1", bus.rd_ack_o, bus.wr_ack_o); end
        apply('0, '0, 1'b0, 1'b0);
        total++; if (bus.rd_vld_q_o !== 1'b0 || bus.wr_ack_o !== 1'b0) begin bad++; $display("FAIL ww_after: got vld=%b wr=%b exp 0/0", bus.rd_vld_q_o, bus.wr_ack_o); end
    endtask

    task automatic test_random(input int cycles);
        logic [N-1:0] pend, tag;
        bit pend_wr, cl;
        pend = '0;
        pend_wr = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
                if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) pend_wr = 1'b1;
            tag = N'($urandom);
            cl = ($urandom_range(0, 7) == 0);
            apply(pend, tag, cl, pend_wr);
            total++; if (bus.rd_ack_o !== e_ack) begin bad++; $display("FAIL rnd_ack c%0d: got %b exp %b", c, bus.rd_ack_o, e_ack); end
            total++; if (bus.rd_sel_o !== SW'(e_sel)) begin bad++; $display("FAIL rnd_sel c%0d: got %0d exp %0d", c, bus.rd_sel_o, e_sel); end
            total++; if (bus.wr_ack_o !== e_wr) begin bad++; $display("FAIL rnd_wr c%0d: got %b exp %b", c, bus.wr_ack_o, e_wr); end
            total++; if (bus.rd_vld_q_o !== m_vld) begin bad++; $display("FAIL rnd_vld c%0d: got %b exp %b", c, bus.rd_vld_q_o, m_vld); end
            total++; if (bus.rd_port_q_o !== SW'(m_port)) begin bad++; $display("FAIL rnd_port c%0d: got %0d exp %0d", c, bus.rd_port_q_o, m_port); end
            total++; if (bus.rd_tag_only_q_o !== m_tag) begin bad++; $display("FAIL rnd_tag c%0d: got %b exp %b", c, bus.rd_tag_only_q_o, m_tag); end
            total++; if (bus.wr_ack_o === 1'b1 && bus.rd_ack_o !== 4'b0000) begin bad++; $display("FAIL rnd_excl c%0d: got rd=%b wr=1 exp exclusive", c, bus.rd_ack_o); end
            pend = pend & ~e_ack;
            if (e_wr) pend_wr = 1'b0;
        end
        apply('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hp_rr();
        test_lp_starve();
        test_cl_block();
        test_both_forced();
        test_reset_mid();
        test_word_write();
        test_random(400);
        prio = 4'b0101;
        do_reset();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
